// File: rtl/bank_rowbuf.sv
// bank_rowbuf: one DRAM bank with open-row tracking, ACT/RD/WR/PRE and tRCD/tRP/CL timers; RDA/WRA exist only under BANK_AUTO_PRECHARGE_EN.
// Read beats appear T_CL..T_CL+BL-1 cycles after accept; cmd_ready is a registered state decode held low through every timer and burst.
module bank_rowbuf #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int ROWWIDTH     = 5,
    parameter int BL           = 8,
    parameter int T_RCD        = 3,
    parameter int T_RP         = 3,
    parameter int T_CL         = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd,
    input  logic [ROWWIDTH-1:0]     row,
    input  logic [COLWIDTH-1:0]     column,
    input  logic [DEVICE_WIDTH-1:0] dqin,
    output logic [DEVICE_WIDTH-1:0] dqout,
    output logic                    dqout_valid,
    output logic                    row_open,
    output logic [ROWWIDTH-1:0]     open_row,
    output logic                    err
);
    localparam int DEPTH = 1 << (ROWWIDTH + COLWIDTH);
    localparam int CNTW  = $clog2(T_RCD + T_RP + T_CL + BL + 1) + 1;
    localparam logic [COLWIDTH-1:0] BLK_MASK = COLWIDTH'(BL - 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATING,
        S_ACTIVE,
        S_WRITING,
        S_READING,
        S_PRECHARGING
    } state_t;

    state_t                  state;
    logic [CNTW-1:0]         cnt;
    logic [COLWIDTH-1:0]     col_base;
    logic [DEVICE_WIDTH-1:0] mem [DEPTH];

    logic                            accept;
    logic                            is_rd;
    logic                            is_wr;
    logic                            auto_now;
    logic                            wr_en;
    logic [ROWWIDTH+COLWIDTH-1:0]    wr_addr;
    logic [CNTW-1:0]                 nxt_off;
    logic                            rd_in_burst;
    logic                            rd_first;
    logic                            rd_beat;
    logic [COLWIDTH-1:0]             rd_k;
    logic [ROWWIDTH+COLWIDTH-1:0]    rd_addr;
    logic                            wr_last;
    logic                            rd_last;
    logic                            burst_end;
    logic                            start_pre;
    logic                            to_active;

    // Sequential order inside the aligned BL block; bits above the block never move.
    function automatic logic [COLWIDTH-1:0] burst_col(input logic [COLWIDTH-1:0] base,
                                                      input logic [COLWIDTH-1:0] idx);
        logic [COLWIDTH-1:0] sum;
        sum = base + idx;
        return (base & ~BLK_MASK) | (sum & BLK_MASK);
    endfunction

    assign accept = cmd_valid && cmd_ready && (cmd != CMD_NOP);

`ifdef BANK_AUTO_PRECHARGE_EN
    localparam logic [2:0] CMD_RDA = 3'd5;
    localparam logic [2:0] CMD_WRA = 3'd6;
    logic auto_pre;
    logic is_auto;
    assign is_rd    = (cmd == CMD_RD) || (cmd == CMD_RDA);
    assign is_wr    = (cmd == CMD_WR) || (cmd == CMD_WRA);
    assign is_auto  = (cmd == CMD_RDA) || (cmd == CMD_WRA);
    assign auto_now = (state == S_ACTIVE) ? is_auto : auto_pre;
`else
    assign is_rd    = (cmd == CMD_RD);
    assign is_wr    = (cmd == CMD_WR);
    assign auto_now = 1'b0;
`endif

    assign wr_en   = ((state == S_ACTIVE) && accept && is_wr) || (state == S_WRITING);
    assign wr_addr = {open_row, (state == S_WRITING) ? burst_col(col_base, COLWIDTH'(cnt)) : column};

    // Beat registered at this edge is the one shown in the next cycle (offset cnt+1 from accept).
    assign nxt_off     = cnt + 1'b1;
    assign rd_in_burst = (state == S_READING) && (nxt_off >= CNTW'(T_CL)) && (nxt_off < CNTW'(T_CL + BL));
    assign rd_first    = (T_CL == 1) && (state == S_ACTIVE) && accept && is_rd;
    assign rd_beat     = rd_in_burst || rd_first;
    assign rd_k        = rd_in_burst ? COLWIDTH'(nxt_off - CNTW'(T_CL)) : '0;
    assign rd_addr     = {open_row, burst_col(rd_in_burst ? col_base : column, rd_k)};

    assign wr_last   = ((state == S_WRITING) && (cnt == CNTW'(BL - 1)))
                     || ((BL == 1) && (state == S_ACTIVE) && accept && is_wr);
    assign rd_last   = (state == S_READING) && (cnt == CNTW'(T_CL + BL - 1));
    assign burst_end = wr_last || rd_last;
    assign start_pre = (burst_end && auto_now) || ((state == S_ACTIVE) && accept && (cmd == CMD_PRE));
    assign to_active = burst_end && !auto_now;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= dqin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            col_base    <= '0;
            cmd_ready   <= 1'b1;
            dqout       <= '0;
            dqout_valid <= 1'b0;
            row_open    <= 1'b0;
            open_row    <= '0;
            err         <= 1'b0;
`ifdef BANK_AUTO_PRECHARGE_EN
            auto_pre    <= 1'b0;
`endif
        end else begin
            err         <= 1'b0;
            dqout       <= '0;
            dqout_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd == CMD_ACT) begin
                            open_row <= row;
                            row_open <= 1'b1;
                            if (T_RCD == 1) begin
                                state <= S_ACTIVE;
                            end else begin
                                state     <= S_ACTIVATING;
                                cnt       <= CNTW'(T_RCD - 2);
                                cmd_ready <= 1'b0;
                            end
                        end else if (cmd != CMD_PRE) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ACTIVATING: begin
                    if (cnt == '0) begin
                        state     <= S_ACTIVE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (accept) begin
                        if (is_wr || is_rd) begin
                            col_base  <= column;
                            cnt       <= CNTW'(1);
                            state     <= is_wr ? S_WRITING : S_READING;
                            cmd_ready <= 1'b0;
`ifdef BANK_AUTO_PRECHARGE_EN
                            auto_pre  <= is_auto;
`endif
                        end else if (cmd != CMD_PRE) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_WRITING, S_READING: begin
                    cnt <= cnt + 1'b1;
                end
                S_PRECHARGING: begin
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase

            if (rd_beat) begin
                dqout       <= mem[rd_addr];
                dqout_valid <= 1'b1;
            end

            // Burst completion and explicit PRE override the per-state next values above.
            if (start_pre) begin
                row_open <= 1'b0;
                if (T_RP == 1) begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end else begin
                    state     <= S_PRECHARGING;
                    cnt       <= CNTW'(T_RP - 2);
                    cmd_ready <= 1'b0;
                end
            end else if (to_active) begin
                state     <= S_ACTIVE;
                cmd_ready <= 1'b1;
            end
        end
    end
endmodule
